// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared types and encodings for the multicycle ARM controller.
//   state_t       - controller FSM states (BLINK only exists when BL_EN is defined)
//   ALU_*         - ALUControl operation codes
//   CMD_*         - data-processing cmd field values that are decoded
//   COND_*        - condition field encodings
//   RES_*/SRCB_*  - ResultSrc and ALUSrcB mux selects
//   IMM_*/OP_*    - ImmSrc formats and Op field values
// Configuration macro: BL_EN (adds the BLINK state).
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
`ifdef BL_EN
    S_BRANCH = 4'd9,
    S_BLINK  = 4'd10
`else
    S_BRANCH = 4'd9
`endif
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/arm_multicycle_ctrl_if.sv
// arm_multicycle_ctrl_if: controller <-> datapath signal bundle.
//   master (controller): in Instr[31:0], AluFlags[3:0] ({V,C,N,Z});
//                        out PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//                        LinkSel, ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0],
//                        ALUControl[1:0], ImmSrc[1:0], RegSrc[1:0], Flags[3:0]
//   slave  (datapath):   the same signals with directions reversed.
interface arm_multicycle_ctrl_if;
  import arm_ctrl_pkg::*;

  logic [31:0] Instr;
  logic [3:0]  AluFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        LinkSel;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [3:0]  Flags;

  modport master (
    input  Instr, AluFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, LinkSel,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags
  );

  modport slave (
    output Instr, AluFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, LinkSel,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags
  );
endinterface

// File: rtl/arm_cond_check.sv
// arm_cond_check: combinational ARM condition-code evaluation.
//   i_cond[3:0]  - Cond field of the instruction
//   i_flags[3:0] - flags register, [3]=V [2]=C [1]=N [0]=Z
//   o_cond_ex    - 1 when the instruction should execute (Cond=1111 -> 0)
module arm_cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_v, w_c, w_n, w_z, w_ge;

  assign w_v  = i_flags[3];
  assign w_c  = i_flags[2];
  assign w_n  = i_flags[1];
  assign w_z  = i_flags[0];
  assign w_ge = (w_n == w_v);

  always_comb begin
    o_cond_ex = 1'b0;
    unique case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = w_ge;
      COND_LT: o_cond_ex = ~w_ge;
      COND_GT: o_cond_ex = ~w_z & w_ge;
      COND_LE: o_cond_ex = w_z | ~w_ge;
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: control FSM for a multicycle ARM datapath.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (state=FETCH, Flags=0, write enables 0)
//   bus  - master side of arm_multicycle_ctrl_if (Instr/AluFlags in,
//          mux selects, write enables, ImmSrc/RegSrc and Flags out)
// Parameter LINK_REG: register written by BL; the datapath applies it when
// LinkSel is high.
// Configuration macro: BL_EN - adds the BLINK state so BL writes the link
// register before branching; without it BL executes as B and LinkSel is 0.
module arm_multicycle_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned LINK_REG = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  arm_multicycle_ctrl_if.master bus
);

  // Only r0..r15 exist; an out-of-range index would be a wiring error upstream.
  if (LINK_REG > 15) begin : g_link_reg_out_of_range
  end

  state_t r_state, w_next;
  logic   r_cond_ex;
  logic [3:0] r_flags;

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic       w_i, w_s, w_l;
  logic [3:0] w_cmd;
  logic       w_cond_ex;
  logic       w_unused_instr;

  assign w_cond         = bus.Instr[31:28];
  assign w_op           = bus.Instr[27:26];
  assign w_funct        = bus.Instr[25:20];
  assign w_i            = w_funct[5];
  assign w_s            = w_funct[0];
  assign w_l            = w_funct[0];
  assign w_cmd          = w_funct[4:1];
  assign w_unused_instr = ^bus.Instr[19:0];

  arm_cond_check u_cond_check (
    .i_cond    (w_cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  // Data-processing cmd decode; CMP forces flag setting, unknown cmds are
  // harmless ADDs that neither write a register nor touch the flags.
  logic [1:0] w_dp_alu;
  logic       w_no_write, w_s_eff;

  always_comb begin
    w_dp_alu   = ALU_ADD;
    w_no_write = 1'b0;
    w_s_eff    = w_s;
    unique case (w_cmd)
      CMD_ADD: w_dp_alu = ALU_ADD;
      CMD_SUB: w_dp_alu = ALU_SUB;
      CMD_AND: w_dp_alu = ALU_AND;
      CMD_ORR: w_dp_alu = ALU_ORR;
      CMD_CMP: begin
        w_dp_alu   = ALU_SUB;
        w_no_write = 1'b1;
        w_s_eff    = 1'b1;
      end
      default: begin
        w_dp_alu   = ALU_ADD;
        w_no_write = 1'b1;
        w_s_eff    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_cond_ex <= 1'b0;
      r_flags   <= '0;
    end else begin
      r_state <= w_next;
      // Condition is frozen at DECODE, so flags written by this instruction's
      // own EXEC step can never influence its write-back.
      if (r_state == S_DECODE)
        r_cond_ex <= w_cond_ex;
      if ((r_state == S_EXECR || r_state == S_EXECI) && w_s_eff && r_cond_ex)
        r_flags <= bus.AluFlags;
    end
  end

  logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
  logic       w_link_sel, w_alu_src_a;
  logic [1:0] w_result_src, w_alu_src_b, w_alu_control;

  always_comb begin
    w_next        = S_FETCH;
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_link_sel    = 1'b0;
    w_result_src  = RES_ALUOUT;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = SRCB_RM;
    w_alu_control = ALU_ADD;
    unique case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU;
        w_pc_write   = 1'b1;
        w_next       = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        unique case (w_op)
          OP_DP:  w_next = w_i ? S_EXECI : S_EXECR;
          OP_MEM: w_next = S_MEMADR;
`ifdef BL_EN
          OP_BR:  w_next = w_funct[4] ? S_BLINK : S_BRANCH;
`else
          OP_BR:  w_next = S_BRANCH;
`endif
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_b = SRCB_IMM;
        w_next      = w_l ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr_src = 1'b1;
        w_next    = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = r_cond_ex;
      end
      S_MEMWR: begin
        w_adr_src   = 1'b1;
        w_mem_write = r_cond_ex;
      end
      S_EXECR: begin
        w_alu_control = w_dp_alu;
        w_next        = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_b   = SRCB_IMM;
        w_alu_control = w_dp_alu;
        w_next        = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = r_cond_ex & ~w_no_write;
      end
      S_BRANCH: begin
        w_alu_src_b  = SRCB_IMM;
        w_result_src = RES_ALU;
        w_pc_write   = r_cond_ex;
      end
`ifdef BL_EN
      S_BLINK: begin
        // PC already points past the BL, so PC+0 is the return address.
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_ZERO;
        w_result_src = RES_ALU;
        w_link_sel   = 1'b1;
        w_reg_write  = r_cond_ex;
        w_next       = S_BRANCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // Reset already forces FETCH; only the write strobes need masking.
  assign bus.PCWrite    = w_pc_write  & ~rst;
  assign bus.IRWrite    = w_ir_write  & ~rst;
  assign bus.RegWrite   = w_reg_write & ~rst;
  assign bus.MemWrite   = w_mem_write & ~rst;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.LinkSel    = w_link_sel;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.ALUControl = w_alu_control;
  assign bus.Flags      = r_flags;

  assign bus.ImmSrc = (w_op == OP_MEM) ? IMM_MEM :
                      (w_op == OP_BR)  ? IMM_BR  : IMM_DP;
  assign bus.RegSrc = {(w_op == OP_MEM) & ~w_l, (w_op == OP_BR)};

endmodule
